adc_capture_ctrl: RTL

Sequences one capture run on the 96-lane x 9-bit ADC/packet-generator data bus. Owns the data-source select (rf_self_mode) and changes it only while idle, followed by a settle window. Arms on start, waits for a trigger, then issues buffer write strobes and addresses for a programmed number of bus words. Sits between the register file and the source mux / capture buffer in pktctrl.

---
 rtl/adc_capture_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl
// ----------------------------------------------------------------------------
// Runs one capture on the 96-lane x 9-bit ADC / packet-generator bus.
// The block owns the source select (rf_self_mode) and changes it only when
// leaving IDLE. A change is followed by a settle window before the run arms.
// An armed run waits for a trigger (ADC source) or starts at once (packet
// generator), then issues cap_wr_len buffer writes at addresses 0..len-1.
//
// Optional feature, enabled by defining ADC_CAP_TRIG_TIMEOUT_EN:
//   While ARMED on the ADC source, a counter loaded from cfg_tmo at start
//   counts down. If it runs out before trig, the run ends with an err pulse.
//   cfg_tmo = 0 disables the timeout. Without the macro the counter is
//   absent and cfg_tmo is ignored. The port list is the same in both builds.
//
// Ports:
//   clk, rst          capture clock; asynchronous active-high reset
//   cfg_self_mode     requested source (1 = packet generator, 0 = ADC)
//   cfg_cap_len       words to capture, sampled at start (0 = error)
//   cfg_tmo           trigger timeout in cycles, sampled at start
//   start             one-cycle run request, honoured only in IDLE
//   abort             ends the run from any non-IDLE state
//   trig              ADC trigger, level-sampled in ARMED
//   buf_ready         capture buffer accepts a write this cycle
//   rf_self_mode      source select to the mux
//   pkt_gen_en        packet generator enable (ARMED/CAPTURE, self mode)
//   cap_wr_en         buffer write strobe
//   cap_wr_addr       buffer write address
//   busy              high in every state except IDLE
//   done              one-cycle pulse on normal completion
//   err               one-cycle pulse on abort, zero length or timeout
//
// Write handshake: a word is transferred in every cycle where cap_wr_en is
// high. cap_wr_en is only ever high when buf_ready is high, so the buffer
// sees a strobe exactly on the cycles it can accept it; cap_wr_addr advances
// by one after each such cycle and holds otherwise.
// ----------------------------------------------------------------------------
module adc_capture_ctrl #(
    parameter int ADDR_W     = 10,
    parameter int SETTLE_CYC = 4,
    parameter int TMO_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_self_mode,
    input  logic [ADDR_W:0]   cfg_cap_len,
    input  logic [TMO_W-1:0]  cfg_tmo,
    input  logic              start,
    input  logic              abort,
    input  logic              trig,
    input  logic              buf_ready,
    output logic              rf_self_mode,
    output logic              pkt_gen_en,
    output logic              cap_wr_en,
    output logic [ADDR_W-1:0] cap_wr_addr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SWITCH  = 3'd1;
    localparam logic [2:0] S_ARMED   = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_FINISH  = 3'd4;

    localparam int              SET_W    = $clog2(SETTLE_CYC + 1);
    localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYC - 1);
    localparam logic [ADDR_W:0] LEN_ONE  = (ADDR_W + 1)'(1);

    // FSM state, kept as a plainly named signal for checkers to bind to.
    logic [2:0]       state;
    logic [ADDR_W:0]  len_lat;
    logic [SET_W-1:0] settle_cnt;
    logic             err_q;
    logic             last_write;

    // The final word sits at address len-1; for a full 2^ADDR_W run that is
    // all ones and the address register wraps to 0 afterwards.
    assign last_write = ({1'b0, cap_wr_addr} == (len_lat - LEN_ONE));

`ifdef ADC_CAP_TRIG_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);
    logic [TMO_W-1:0] tmo_cnt;
`else
    logic unused_tmo;
    assign unused_tmo = ^cfg_tmo;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            rf_self_mode <= 1'b0;
            len_lat      <= '0;
            settle_cnt   <= '0;
            cap_wr_addr  <= '0;
            err_q        <= 1'b0;
`ifdef ADC_CAP_TRIG_TIMEOUT_EN
            tmo_cnt      <= '0;
`endif
        end else begin
            err_q <= 1'b0;
            // abort outranks every transition, but IDLE ignores it so that a
            // start in the same cycle still launches a run.
            if (abort && state != S_IDLE) begin
                state <= S_IDLE;
                err_q <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            len_lat     <= cfg_cap_len;
                            cap_wr_addr <= '0;
`ifdef ADC_CAP_TRIG_TIMEOUT_EN
                            tmo_cnt     <= cfg_tmo;
`endif
                            if (cfg_cap_len == '0) begin
                                err_q <= 1'b1;
                            end else if (cfg_self_mode != rf_self_mode) begin
                                state        <= S_SWITCH;
                                rf_self_mode <= cfg_self_mode;
                                settle_cnt   <= SET_LOAD;
                            end else begin
                                state <= S_ARMED;
                            end
                        end
                    end
                    S_SWITCH: begin
                        if (settle_cnt == '0) begin
                            state <= S_ARMED;
                        end else begin
                            settle_cnt <= settle_cnt - 1'b1;
                        end
                    end
                    S_ARMED: begin
                        if (rf_self_mode || trig) begin
                            state <= S_CAPTURE;
`ifdef ADC_CAP_TRIG_TIMEOUT_EN
                        end else if (tmo_cnt == TMO_ONE) begin
                            state <= S_IDLE;
                            err_q <= 1'b1;
                        end else if (tmo_cnt != '0) begin
                            tmo_cnt <= tmo_cnt - TMO_ONE;
`endif
                        end
                    end
                    S_CAPTURE: begin
                        if (buf_ready) begin
                            cap_wr_addr <= cap_wr_addr + 1'b1;
                            if (last_write) begin
                                state <= S_FINISH;
                            end
                        end
                    end
                    S_FINISH: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign cap_wr_en  = (state == S_CAPTURE) && buf_ready;
    assign pkt_gen_en = rf_self_mode && ((state == S_ARMED) || (state == S_CAPTURE));
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_FINISH);
    assign err        = err_q;

endmodule
